// File: rtl/cla_seq_subtractor.sv
// cla_seq_subtractor
//   Multi-cycle W-bit subtractor computing d = a - b - bin (modulo 2^W).
//   One G-bit slice is processed per clock, least significant slice first.
//   Each slice is evaluated as a + ~b + carry with carry-lookahead logic.
//   The slice carry-out is registered and feeds the next slice.
//   Only one operation is in flight at a time.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands presented
//   in_ready   block can accept operands (high only in IDLE)
//   a, b, bin  minuend, subtrahend, borrow in
//   out_valid  result available (high only in DONE)
//   out_ready  consumer accepts result
//   d          difference, modulo 2^W
//   bout       borrow out (unsigned a < b + bin)
//   ovf        signed overflow
//   zero       d == 0
module cla_seq_subtractor #(
  parameter int W = 16,
  parameter int G = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] d,
  output logic         bout,
  output logic         ovf,
  output logic         zero
);

  localparam int NS = W / G;
  localparam int KW = (NS > 1) ? $clog2(NS) : 1;

  // Elaboration-time guard: a partial top slice is not supported.
  generate
    if ((W % G) != 0 || W < G) begin : g_bad_params
      $error("cla_seq_subtractor: W must be a non-zero multiple of G");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_reg, state_next;
  logic [W-1:0]  a_reg, b_reg, d_reg;
  logic [W-1:0]  d_next;
  logic [KW-1:0] k_reg;
  logic          carry_reg;
  logic          bout_reg, ovf_reg, zero_reg;

  logic          accept;
  logic          last_slice;
  logic [G-1:0]  a_slice, b_slice;
  logic [G-1:0]  p, g, s;
  logic [G:0]    c;

  assign in_ready   = (state_reg == IDLE);
  assign out_valid  = (state_reg == DONE);
  assign accept     = in_valid && in_ready;
  assign last_slice = (k_reg == KW'(NS - 1));

  assign a_slice = a_reg[k_reg*G +: G];
  assign b_slice = b_reg[k_reg*G +: G];
  assign c[0]    = carry_reg;

  // Per-bit propagate/generate for a + ~b, and a flattened lookahead carry
  // for every bit position: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c[0].
  // No carry term depends on a lower-order carry, so the slice has no ripple.
  generate
    for (genvar gi = 0; gi < G; gi++) begin : g_cla
      logic cout_bit;

      assign p[gi] = a_slice[gi] ^ ~b_slice[gi];
      assign g[gi] = a_slice[gi] & ~b_slice[gi];

      always_comb begin
        logic acc;
        logic term;
        acc = carry_reg;
        for (int j = 0; j <= gi; j++) begin
          acc = acc & p[j];
        end
        for (int j = 0; j <= gi; j++) begin
          term = g[j];
          for (int m = j + 1; m <= gi; m++) begin
            term = term & p[m];
          end
          acc = acc | term;
        end
        cout_bit = acc;
      end

      assign c[gi+1] = cout_bit;
      assign s[gi]   = p[gi] ^ c[gi];
    end
  endgenerate

  // Difference with the current slice merged in; on the last slice this is
  // the final result, which is what the flags must be derived from.
  always_comb begin
    d_next = d_reg;
    d_next[k_reg*G +: G] = s;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last_slice) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      d_reg     <= '0;
      k_reg     <= '0;
      carry_reg <= 1'b0;
      bout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      zero_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_reg     <= a;
            b_reg     <= b;
            // Subtraction as a + ~b + 1 - bin: the initial carry is ~bin.
            carry_reg <= ~bin;
            k_reg     <= '0;
            d_reg     <= '0;
          end
        end
        RUN: begin
          d_reg     <= d_next;
          carry_reg <= c[G];
          k_reg     <= k_reg + KW'(1);
          if (last_slice) begin
            bout_reg <= ~c[G];
            ovf_reg  <= (a_reg[W-1] != b_reg[W-1]) && (d_next[W-1] != a_reg[W-1]);
            zero_reg <= (d_next == '0);
          end
        end
        default: begin
          // DONE: result and flags held until the consumer takes them.
        end
      endcase
    end
  end

  assign d    = d_reg;
  assign bout = bout_reg;
  assign ovf  = ovf_reg;
  assign zero = zero_reg;

endmodule
